// File: rtl/sobel_edge_stage_pkg.sv
`default_nettype none
//==============================================================================
// Module      : sobel_edge_stage_pkg
// Description : Frame geometry, sweep FSM encoding and Sobel helpers
// Revision    : 1.0 - initial release
//==============================================================================
package sobel_edge_stage_pkg;

    localparam int IMG_W     = 120;
    localparam int IMG_H     = 120;
    localparam int PIX_W     = 4;
    localparam int ADDR_W    = 14;
    localparam int MAG_W     = 7;
    localparam int COORD_W   = $clog2(IMG_W);
    localparam int FRAME_PIX = IMG_W * IMG_H;
    localparam int SUM_W     = PIX_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_t;

    // One Sobel arm: outer taps weighted 1, middle tap weighted 2.
    function automatic logic [SUM_W-1:0] sobel_tap_sum(
        input logic [PIX_W-1:0] a,
        input logic [PIX_W-1:0] m,
        input logic [PIX_W-1:0] b
    );
        return SUM_W'(a) + SUM_W'({m, 1'b0}) + SUM_W'(b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_line_buffer.sv
`default_nettype none
//==============================================================================
// Module      : sobel_line_buffer
// Description : One-line delay, read-before-write at the same column address
// Revision    : 1.0 - initial release
//==============================================================================
module sobel_line_buffer
    import sobel_edge_stage_pkg::*;
#(
    parameter int DEPTH = IMG_W,
    parameter int WIDTH = PIX_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             rw_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge rw_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sobel_edge_stage.sv
`default_nettype none
//==============================================================================
// Module      : sobel_edge_stage
// Description : Single-pass gray frame sweep producing thresholded Sobel edges
// Revision    : 1.0 - initial release
//==============================================================================
module sobel_edge_stage
    import sobel_edge_stage_pkg::*;
#(
    parameter int unsigned THRESH = 24
) (
    input  logic              rw_clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] r_addr_gray,
    input  logic [PIX_W-1:0]  d_in_gray,
    output logic              edge_we,
    output logic [ADDR_W-1:0] edge_addr,
    output logic              edge_bit,
    output logic [MAG_W-1:0]  edge_mag
);

    localparam logic [ADDR_W-1:0]  c_last_addr  = ADDR_W'(FRAME_PIX - 1);
    localparam logic [ADDR_W-1:0]  c_centre_ofs = ADDR_W'(IMG_W + 1);
    localparam logic [COORD_W-1:0] c_last_col   = COORD_W'(IMG_W - 1);

    sweep_state_t              r_state;
    sweep_state_t              w_state_nxt;
    logic                      w_accept;
    logic [1:0]                r_drain_cnt;
    logic [ADDR_W-1:0]         r_rd_addr;
    logic                      r_rd_vld;
    logic [COORD_W-1:0]        r_col;
    logic [COORD_W-1:0]        r_row;
    logic [ADDR_W-1:0]         r_pix_idx;
    logic [PIX_W-1:0]          w_line0;
    logic [PIX_W-1:0]          w_line1;
    logic [2:0][2:0][PIX_W-1:0] r_win;
    logic                      r_win_vld;
    logic [ADDR_W-1:0]         r_win_addr;
    logic [SUM_W-1:0]          w_gx_pos;
    logic [SUM_W-1:0]          w_gx_neg;
    logic [SUM_W-1:0]          w_gy_pos;
    logic [SUM_W-1:0]          w_gy_neg;
    logic [MAG_W-1:0]          w_gx;
    logic [MAG_W-1:0]          w_gy;
    logic [MAG_W-1:0]          w_abs_gx;
    logic [MAG_W-1:0]          w_abs_gy;
    logic [MAG_W-1:0]          w_mag;
    logic                      r_edge_we;
    logic                      r_edge_bit;
    logic [ADDR_W-1:0]         r_edge_addr;
    logic [MAG_W-1:0]          r_edge_mag;

    assign w_accept = (r_state == ST_IDLE) && start;

    always_ff @(posedge rw_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_READ;
            ST_READ:  if (r_rd_addr == c_last_addr) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_drain_cnt == 2'd2) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (r_state == ST_READ) || (r_state == ST_DRAIN);
    assign done = (r_state == ST_DONE);

    always_ff @(posedge rw_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain_cnt <= 2'd0;
            r_rd_addr   <= '0;
            r_rd_vld    <= 1'b0;
        end else begin
            r_rd_vld    <= (r_state == ST_READ);
            r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
            if (w_accept) begin
                r_rd_addr <= '0;
            end else if ((r_state == ST_READ) && (r_rd_addr != c_last_addr)) begin
                r_rd_addr <= r_rd_addr + ADDR_W'(1);
            end
        end
    end

    assign r_addr_gray = r_rd_addr;

    sobel_line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) u_line0 (
        .rw_clk  (rw_clk),
        .i_we    (r_rd_vld),
        .i_addr  (r_col),
        .i_wdata (d_in_gray),
        .o_rdata (w_line0)
    );

    sobel_line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) u_line1 (
        .rw_clk  (rw_clk),
        .i_we    (r_rd_vld),
        .i_addr  (r_col),
        .i_wdata (w_line0),
        .o_rdata (w_line1)
    );

    // Row/col tag the pixel arriving this cycle; window column 2 is the newest.
    always_ff @(posedge rw_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col      <= '0;
            r_row      <= '0;
            r_pix_idx  <= '0;
            r_win      <= '0;
            r_win_vld  <= 1'b0;
            r_win_addr <= '0;
        end else begin
            r_win_vld <= r_rd_vld && (r_row >= COORD_W'(2)) && (r_col >= COORD_W'(2));
            if (w_accept) begin
                r_col     <= '0;
                r_row     <= '0;
                r_pix_idx <= '0;
            end else if (r_rd_vld) begin
                if (r_col == c_last_col) begin
                    r_col <= '0;
                    r_row <= r_row + COORD_W'(1);
                end else begin
                    r_col <= r_col + COORD_W'(1);
                end
                r_pix_idx <= r_pix_idx + ADDR_W'(1);
            end
            if (r_rd_vld) begin
                r_win_addr <= r_pix_idx - c_centre_ofs;
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= w_line1;
                r_win[1][2] <= w_line0;
                r_win[2][2] <= d_in_gray;
            end
        end
    end

    assign w_gx_pos = sobel_tap_sum(r_win[0][2], r_win[1][2], r_win[2][2]);
    assign w_gx_neg = sobel_tap_sum(r_win[0][0], r_win[1][0], r_win[2][0]);
    assign w_gy_pos = sobel_tap_sum(r_win[2][0], r_win[2][1], r_win[2][2]);
    assign w_gy_neg = sobel_tap_sum(r_win[0][0], r_win[0][1], r_win[0][2]);

    // Each arm is at most 60, so the 7-bit two's complement difference never wraps.
    assign w_gx     = MAG_W'(w_gx_pos) - MAG_W'(w_gx_neg);
    assign w_gy     = MAG_W'(w_gy_pos) - MAG_W'(w_gy_neg);
    assign w_abs_gx = w_gx[MAG_W-1] ? (-w_gx) : w_gx;
    assign w_abs_gy = w_gy[MAG_W-1] ? (-w_gy) : w_gy;
    assign w_mag    = w_abs_gx + w_abs_gy;

    always_ff @(posedge rw_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge_we   <= 1'b0;
            r_edge_bit  <= 1'b0;
            r_edge_addr <= '0;
            r_edge_mag  <= '0;
        end else begin
            r_edge_we <= r_win_vld;
            if (r_win_vld) begin
                r_edge_addr <= r_win_addr;
                r_edge_mag  <= w_mag;
                r_edge_bit  <= (w_mag >= MAG_W'(THRESH));
            end
        end
    end

    assign edge_we   = r_edge_we;
    assign edge_addr = r_edge_addr;
    assign edge_bit  = r_edge_bit;
    assign edge_mag  = r_edge_mag;

endmodule
`default_nettype wire

// File: tb/tb_sobel_edge_stage.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module      : tb_sobel_edge_stage
// Description : Directed-vector bench for the Sobel frame-sweep stage
// Revision    : 1.0 - initial release
//==============================================================================
module tb_sobel_edge_stage;

    localparam int W     = 120;
    localparam int FRAME = 14400;

    logic        rw_clk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic        busy;
    logic        done;
    logic [13:0] r_addr_gray;
    logic [3:0]  d_in_gray;
    logic        edge_we;
    logic [13:0] edge_addr;
    logic        edge_bit;
    logic [6:0]  edge_mag;

    int pattern  = 0;
    int checks   = 0;
    int failures = 0;

    int we_cnt, order_err, done_cnt, done_n, busy_cnt, addr_err, last_addr, first_nz;
    int     cap_mag [FRAME];
    bit     cap_bit [FRAME];
    bit     cap_wr  [FRAME];

    typedef struct {
        int pat;
        int addr;
        int mag;
        int bt;
    } vec_t;
    vec_t vecs [17];

    sobel_edge_stage #(.THRESH(24)) dut (
        .rw_clk      (rw_clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .r_addr_gray (r_addr_gray),
        .d_in_gray   (d_in_gray),
        .edge_we     (edge_we),
        .edge_addr   (edge_addr),
        .edge_bit    (edge_bit),
        .edge_mag    (edge_mag)
    );

    always #10 rw_clk = ~rw_clk;

    function automatic logic [3:0] pix(input int pat, input int a);
        int r, c;
        r = a / W;
        c = a % W;
        case (pat)
            0: return 4'd7;
            1: return (c >= 60) ? 4'd15 : 4'd0;
            2: return (r >= 60) ? 4'd15 : 4'd0;
            default: begin
                if (r == 50 && c == 50) return 4'd15;
                if (r == 20 && c == 20) return 4'd12;
                if (r == 20 && c == 90) return 4'd10;
                return 4'd0;
            end
        endcase
    endfunction

    // Registered-read gray buffer
    always @(posedge rw_clk) d_in_gray <= pix(pattern, int'(r_addr_gray));

    function automatic bit near(input int r, input int c, input int r0, input int c0);
        return (r >= r0 - 1) && (r <= r0 + 1) && (c >= c0 - 1) && (c <= c0 + 1) && !(r == r0 && c == c0);
    endfunction

    function automatic int exp_mag(input int pat, input int r, input int c);
        case (pat)
            0: return 0;
            1: return (c == 59 || c == 60) ? 60 : 0;
            2: return (r == 59 || r == 60) ? 60 : 0;
            default: begin
                if (near(r, c, 50, 50)) return 30;
                if (near(r, c, 20, 20)) return 24;
                if (near(r, c, 20, 90)) return 20;
                return 0;
            end
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_pass(input int pat, input bit hold, input bit pulses);
        int  n;
        int  exp_r, exp_c;
        bit  first;
        pattern = pat;
        for (int i = 0; i < FRAME; i++) begin
            cap_wr[i]  = 1'b0;
            cap_bit[i] = 1'b0;
            cap_mag[i] = 0;
        end
        we_cnt = 0; order_err = 0; done_cnt = 0; done_n = -1; busy_cnt = 0;
        addr_err = 0; last_addr = -1; first_nz = -1;
        exp_r = 1; exp_c = 1; first = 1'b1; n = 0;
        @(negedge rw_clk);
        start = 1'b1;
        while (done_cnt == 0 && n < 20000) begin
            @(negedge rw_clk);
            n++;
            if (!hold) start = pulses && (n == 100 || n == 5000 || n == 9000);
            if (busy) begin
                busy_cnt++;
                if (first) begin
                    if (r_addr_gray != 14'd0) addr_err++;
                    first = 1'b0;
                end else if (!(int'(r_addr_gray) == last_addr + 1 ||
                               (last_addr == FRAME - 1 && int'(r_addr_gray) == last_addr))) begin
                    addr_err++;
                end
                last_addr = int'(r_addr_gray);
            end
            if (done) begin
                done_cnt++;
                done_n = n;
            end
            if (edge_we) begin
                we_cnt++;
                if (int'(edge_addr) != exp_r * W + exp_c) order_err++;
                if (int'(edge_addr) < FRAME) begin
                    cap_wr[edge_addr]  = 1'b1;
                    cap_mag[edge_addr] = int'(edge_mag);
                    cap_bit[edge_addr] = edge_bit;
                end
                if (first_nz < 0 && edge_mag != 7'd0) first_nz = int'(edge_addr);
                exp_c++;
                if (exp_c == W - 1) begin
                    exp_c = 1;
                    exp_r++;
                end
            end
        end
        if (!hold) begin
            repeat (4) begin
                @(negedge rw_clk);
                if (done) done_cnt++;
                if (edge_we) we_cnt++;
            end
        end
    endtask

    task automatic check_pass(input string name, input int pat);
        int errs;
        int a, em;
        check($sformatf("%s_writes", name), we_cnt, 13924);
        check($sformatf("%s_order", name), order_err, 0);
        check($sformatf("%s_done_count", name), done_cnt, 1);
        check($sformatf("%s_done_cycle", name), done_n, 14404);
        check($sformatf("%s_busy_cycles", name), busy_cnt, 14403);
        check($sformatf("%s_addr_seq", name), addr_err, 0);
        check($sformatf("%s_addr_last", name), last_addr, FRAME - 1);
        errs = 0;
        for (int r = 1; r <= 118; r++) begin
            for (int c = 1; c <= 118; c++) begin
                a  = r * W + c;
                em = exp_mag(pat, r, c);
                if (!cap_wr[a] || cap_mag[a] != em || cap_bit[a] != (em >= 24)) errs++;
            end
        end
        check($sformatf("%s_frame_errors", name), errs, 0);
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].pat == pat) begin
                a = vecs[i].addr;
                check($sformatf("%s_mag@%0d", name, a), cap_wr[a] ? cap_mag[a] : -1, vecs[i].mag);
                check($sformatf("%s_bit@%0d", name, a), cap_wr[a] ? int'(cap_bit[a]) : -1, vecs[i].bt);
            end
        end
    endtask

    initial begin
        int n, quiet;
        vecs[0]  = '{0,   121,  0, 0};
        vecs[1]  = '{0, 14278,  0, 0};
        vecs[2]  = '{1,   179, 60, 1};
        vecs[3]  = '{1,   180, 60, 1};
        vecs[4]  = '{1,  6061,  0, 0};
        vecs[5]  = '{1, 14219, 60, 1};
        vecs[6]  = '{2,  7081, 60, 1};
        vecs[7]  = '{2,  7318, 60, 1};
        vecs[8]  = '{2,  7325,  0, 0};
        vecs[9]  = '{3,  6050,  0, 0};
        vecs[10] = '{3,  6049, 30, 1};
        vecs[11] = '{3,  6171, 30, 1};
        vecs[12] = '{3,  5930, 30, 1};
        vecs[13] = '{3,  2421, 24, 1};
        vecs[14] = '{3,  2299, 24, 1};
        vecs[15] = '{3,  2489, 20, 0};
        vecs[16] = '{3,  2611, 20, 0};

        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge rw_clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_edge_we", edge_we, 0);
        check("rst_edge_bit", edge_bit, 0);
        check("rst_rd_addr", r_addr_gray, 0);
        check("rst_edge_addr", edge_addr, 0);
        check("rst_edge_mag", edge_mag, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge rw_clk);

        // Uniform frame with start held high throughout
        run_pass(0, 1'b1, 1'b0);
        check_pass("uniform", 0);
        @(negedge rw_clk);
        check("held_start_idle", busy, 0);
        @(negedge rw_clk);
        check("held_start_restart", busy, 1);
        start   = 1'b0;
        pattern = 3;

        n = 0;
        while (r_addr_gray != 14'd5000 && n < 10000) begin
            @(negedge rw_clk);
            n++;
        end
        check("abort_reach_5000", r_addr_gray, 5000);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_edge_we", edge_we, 0);
        check("abort_done", done, 0);
        check("abort_rd_addr", r_addr_gray, 0);
        quiet = 0;
        repeat (3) begin
            @(negedge rw_clk);
            if (done || busy || edge_we) quiet++;
        end
        check("abort_quiet", quiet, 0);
        rst_n = 1'b1;
        @(negedge rw_clk);

        run_pass(3, 1'b0, 1'b0);
        check_pass("single", 3);

        run_pass(1, 1'b0, 1'b1);
        check_pass("vstep", 1);

        run_pass(2, 1'b0, 1'b0);
        check_pass("hstep", 2);
        check("hstep_first_edge_addr", first_nz, 7081);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sobel_edge_stage.md
Name: sobel_edge_stage

Overview:
- Downstream consumer of the grayscale frame buffer.
- After a start pulse, sweeps the gray read address once over the 120x120 frame and captures the 4-bit gray pixels returned one cycle later.
- Builds a 3x3 window from two line buffers and computes the Sobel magnitude |Gx|+|Gy|.
- Emits a thresholded 1-bit edge pixel, its magnitude and write address for every interior pixel, feeding the edge-map buffer and the display path.

Parameters:
- IMG_W, 120, frame width in pixels
- IMG_H, 120, frame height in pixels
- PIX_W, 4, gray pixel width
- ADDR_W, 14, pixel address width
- THRESH, 24, edge_bit = 1 when mag >= THRESH

Ports:
- rw_clk  in  1  system clock (50 MHz), all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin one frame pass; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at end of pass
- r_addr_gray  out  ADDR_W  gray buffer read address; the buffer returns data registered, 1 cycle later
- d_in_gray  in  PIX_W  gray pixel from buffer (data for the address of the previous cycle)
- edge_we  out  1  write strobe for edge_addr/edge_bit/edge_mag
- edge_addr  out  ADDR_W  linear address of the window centre pixel
- edge_bit  out  1  thresholded edge
- edge_mag  out  7  |Gx|+|Gy|, range 0..120

Behaviour:
- Reset: FSM goes to IDLE. busy, done, edge_we and edge_bit are 0. r_addr_gray, edge_addr, edge_mag, the counters and the window are 0. Line buffer contents are don't-care; no output depends on them before they are rewritten.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE -> READ on start=1.
- READ: r_addr_gray starts at 0 in the first READ cycle and increments by 1 each cycle. After issuing IMG_W*IMG_H-1 it goes to DRAIN, and r_addr_gray holds its last value.
- DRAIN: lasts exactly 3 cycles, covering the read-data, window and output pipeline stages, then goes to DONE.
- DONE: done=1 for 1 cycle, busy drops in the same cycle, then IDLE.
- start while busy is ignored. A start held high in DONE is not accepted until IDLE.
- Pipeline:
  - cycle t: address A issued.
  - t+1: d_in_gray valid for A. col/row counters (0..IMG_W-1 wrap, row increment on wrap) tag the pixel.
  - t+1: line buffers are read at col. Pixel is pushed into line buffer 0, and the old line0 value into line buffer 1 (one read-then-write per cycle). The 3x3 shift window is loaded with {line1, line0, new}.
  - t+2: window is stable.
  - t+3: edge outputs registered.
  - Total latency from issuing an address to the edge output for the window it completes: 3 cycles.
- Window p[r][c], r and c in 0..2: r=0 is the oldest row, c=0 the leftmost column. The centre is pixel (row-1, col-1) of the newest sample.
- Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20)
- Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02)
- Gx and Gy are signed 7-bit. mag = |Gx| + |Gy| as unsigned 7-bit, with no overflow possible.
- edge_we=1 only when the newest sample has row >= 2 and col >= 2, i.e. for centres on interior pixels 1..IMG_W-2 / 1..IMG_H-2. That gives 118*118 = 13924 writes per pass.
- Border pixels are never written; the edge buffer owner clears them.
- Windows that straddle a row wrap (col < 2) are suppressed.
- edge_addr = (row-1)*IMG_W + (col-1), maintained incrementally with no multiplier.
- edge_addr/edge_bit/edge_mag hold their last values when edge_we=0.
- Reset asserted mid-pass aborts immediately to the reset state. done is not issued.

Decomposition:
- Shared package holds: IMG_W, IMG_H, PIX_W, ADDR_W, MAG_W=7, FSM state encoding (shared with the other frame-sweep stages), and a frame pixel count constant.
- One sub-module: sobel_line_buffer, a single-clock IMG_W x PIX_W read-before-write delay line, instantiated twice.

Test Plan:
- Uniform frame, all pixels 7 -> 13924 edge_we pulses, all edge_mag=0 and edge_bit=0. done pulses once, 14404 cycles after the start-sampling edge. busy is high for 14403 cycles.
- Vertical step, cols 0..59 = 0 and cols 60..119 = 15 -> centres at cols 59 and 60 give mag=60, bit=1. All other interior centres give mag=0. Check edge_addr for (1,59) = 179.
- Horizontal step, rows 0..59 = 0 and rows 60..119 = 15 -> centres at rows 59 and 60 give mag=60 (Gy only). First such write has edge_addr = 59*120+1 = 7081.
- Single pixel of 15 at (50,50), rest 0 -> centre (50,50) mag=0. (50,49), (50,51), (49,50), (51,50) mag=30. The four diagonals mag=30. Bit=1 for these eight, 0 elsewhere.
- Reset control: start held high through a whole pass, and start pulses mid-pass are ignored. rst_n low at pixel 5000 forces busy=0, edge_we=0 and no done. A restart after release runs a full correct pass.
- Address check: r_addr_gray goes 0..14399 contiguously, one per cycle, with no repeats or gaps.
